// File: rtl/sap_memory_unit.sv
// SAP memory stage: MAR, MDR and a 16x8 RAM with a combinational bus read, plus a
// valid/ready program loader. Define MEM_CLEAR_EN to zero the RAM after every reset.
module sap_memory_unit #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] bus_in,
   output logic [DATA_W-1:0] bus_out,
   output logic              bus_oe,
   input  logic              mar_addr_load_n,
   input  logic              mar_mem_load_n,
   input  logic              ram_en_n,
   input  logic              ram_load_n,
   input  logic              prog_mode,
   input  logic              prog_valid,
   input  logic [DATA_W-1:0] prog_data,
   output logic              prog_ready,
   output logic              prog_done,
   output logic              busy
);

   typedef enum logic [1:0] {ST_RUN, ST_PROG, ST_DONE, ST_CLEAR} state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_t            state_q;
   logic [ADDR_W-1:0] mar_q;
   logic [DATA_W-1:0] mdr_q;
   logic [ADDR_W-1:0] prog_ptr_q;
   logic              prog_ready_q;
   logic              prog_done_q;
   logic              busy_q;
`ifdef MEM_CLEAR_EN
   logic [ADDR_W-1:0] clr_ptr_q;
`endif

   logic [DATA_W-1:0] mem [DEPTH];
   logic              we_d;
   logic [ADDR_W-1:0] waddr_d;
   logic [DATA_W-1:0] wdata_d;

   // Single RAM write port shared by the CPU, the loader and the clearer.
   always_comb begin
      we_d    = 1'b0;
      waddr_d = mar_q;
      wdata_d = mdr_q;
      if (rst_n) begin
         case (state_q)
            ST_RUN:  we_d = !ram_load_n;
            ST_PROG: begin
               if (prog_valid && prog_ready_q) begin
                  we_d    = 1'b1;
                  waddr_d = prog_ptr_q;
                  wdata_d = prog_data;
               end
            end
`ifdef MEM_CLEAR_EN
            ST_CLEAR: begin
               we_d    = 1'b1;
               waddr_d = clr_ptr_q;
               wdata_d = '0;
            end
`endif
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (we_d) mem[waddr_d] <= wdata_d;
   end

   // Read is asynchronous so the word reaches the bus in the same cycle as CE.
   assign bus_oe  = rst_n && (state_q == ST_RUN) && !ram_en_n;
   assign bus_out = bus_oe ? mem[mar_q] : '0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mar_q <= '0;
         mdr_q <= '0;
      end else if (state_q == ST_RUN) begin
         if (!mar_addr_load_n) mar_q <= bus_in[ADDR_W-1:0];
         if (!mar_mem_load_n)  mdr_q <= bus_in;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prog_ptr_q   <= '0;
         prog_ready_q <= 1'b0;
         prog_done_q  <= 1'b0;
`ifdef MEM_CLEAR_EN
         clr_ptr_q    <= '0;
         state_q      <= ST_CLEAR;
         busy_q       <= 1'b1;
`else
         state_q      <= ST_RUN;
         busy_q       <= 1'b0;
`endif
      end else begin
         case (state_q)
            ST_RUN: begin
               if (prog_mode) begin
                  state_q      <= ST_PROG;
                  prog_ready_q <= 1'b1;
                  busy_q       <= 1'b1;
               end
            end
            ST_PROG: begin
               if (!prog_mode) begin
                  // Abandoned load: the next one starts again from word 0.
                  state_q      <= ST_RUN;
                  prog_ptr_q   <= '0;
                  prog_ready_q <= 1'b0;
                  busy_q       <= 1'b0;
               end else if (prog_valid) begin
                  prog_ptr_q <= prog_ptr_q + 1'b1;
                  if (prog_ptr_q == LAST_ADDR) begin
                     state_q      <= ST_DONE;
                     prog_ready_q <= 1'b0;
                     prog_done_q  <= 1'b1;
                  end
               end
            end
            ST_DONE: begin
               if (!prog_mode) begin
                  state_q     <= ST_RUN;
                  prog_done_q <= 1'b0;
                  busy_q      <= 1'b0;
               end
            end
`ifdef MEM_CLEAR_EN
            ST_CLEAR: begin
               clr_ptr_q <= clr_ptr_q + 1'b1;
               if (clr_ptr_q == LAST_ADDR) begin
                  state_q <= ST_RUN;
                  busy_q  <= 1'b0;
               end
            end
`endif
            default: state_q <= ST_RUN;
         endcase
      end
   end

   assign prog_ready = prog_ready_q;
   assign prog_done  = prog_done_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_sap_memory_unit.sv
// Bench for sap_memory_unit: directed load/readback table, loader corner cases and
// a randomized run against a cycle-level reference model of the memory stage.
module tb_sap_memory_unit;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] bus_in;
   logic [7:0] bus_out;
   logic       bus_oe;
   logic       mar_addr_load_n, mar_mem_load_n, ram_en_n, ram_load_n;
   logic       prog_mode, prog_valid;
   logic [7:0] prog_data;
   logic       prog_ready, prog_done, busy;

   sap_memory_unit dut (
      .clk(clk), .rst_n(rst_n), .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe),
      .mar_addr_load_n(mar_addr_load_n), .mar_mem_load_n(mar_mem_load_n),
      .ram_en_n(ram_en_n), .ram_load_n(ram_load_n),
      .prog_mode(prog_mode), .prog_valid(prog_valid), .prog_data(prog_data),
      .prog_ready(prog_ready), .prog_done(prog_done), .busy(busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: phase of operation, loaded-word count and RAM image (-1 = unknown).
   localparam int P_RUN = 0, P_PROG = 1, P_DONE = 2, P_CLEAR = 3;
   int m_phase, m_words, m_mar, m_mdr, m_clear_left;
   int m_mem [16];
   bit m_init = 0;

   typedef struct {
      logic       l_ma, l_md, ce, l_r;
      logic [7:0] bin;
      logic       exp_oe;
      logic [7:0] exp_out;
   } vec_t;
   vec_t tbl [14];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_update();
      if (!rst_n) begin
         m_init  = 1;
         m_mar   = 0;
         m_mdr   = 0;
         m_words = 0;
`ifdef MEM_CLEAR_EN
         m_phase      = P_CLEAR;
         m_clear_left = 16;
`else
         m_phase      = P_RUN;
`endif
         return;
      end
      if (!m_init) return;
      case (m_phase)
         P_RUN: begin
            if (!ram_load_n)      m_mem[m_mar] = m_mdr;
            if (!mar_addr_load_n) m_mar = int'(bus_in) % 16;
            if (!mar_mem_load_n)  m_mdr = int'(bus_in);
            if (prog_mode)        m_phase = P_PROG;
         end
         P_PROG: begin
            if (prog_valid) begin
               m_mem[m_words] = int'(prog_data);
               m_words++;
               if (m_words == 16) begin
                  m_words = 0;
                  m_phase = P_DONE;
               end
            end
            if (!prog_mode) begin
               m_phase = P_RUN;
               m_words = 0;
            end
         end
         P_DONE: if (!prog_mode) m_phase = P_RUN;
         default: begin
            m_mem[16 - m_clear_left] = 0;
            m_clear_left--;
            if (m_clear_left == 0) m_phase = P_RUN;
         end
      endcase
   endtask

   // Compare all outputs with the model before the edge, then advance one clock.
   task automatic tick();
      bit e_oe;
      #1;
      if (m_init) begin
         e_oe = rst_n && (m_phase == P_RUN) && !ram_en_n;
         chk("busy", int'(busy), int'(m_phase != P_RUN));
         chk("prog_ready", int'(prog_ready), int'(m_phase == P_PROG));
         chk("prog_done", int'(prog_done), int'(m_phase == P_DONE));
         chk("bus_oe", int'(bus_oe), int'(e_oe));
         if (!e_oe) chk("bus_out_idle", int'(bus_out), 0);
         else if (m_mem[m_mar] >= 0) chk("bus_out", int'(bus_out), m_mem[m_mar]);
      end
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic idle_ctl();
      mar_addr_load_n = 1'b1;
      mar_mem_load_n  = 1'b1;
      ram_en_n        = 1'b1;
      ram_load_n      = 1'b1;
   endtask

   task automatic read_addr(input int a, input int exp);
      idle_ctl();
      mar_addr_load_n = 1'b0;
      bus_in          = 8'(a);
      tick();
      mar_addr_load_n = 1'b1;
      ram_en_n        = 1'b0;
      #1;
      chk($sformatf("read[%0d]", a), int'(bus_out), exp);
      $display("read addr %0d data %02h oe %0b", a, bus_out, bus_oe);
      tick();
      ram_en_n = 1'b1;
   endtask

   task automatic prog_word(input logic [7:0] d);
      prog_valid = 1'b1;
      prog_data  = d;
      tick();
      prog_valid = 1'b0;
   endtask

   task automatic wait_clear();
`ifdef MEM_CLEAR_EN
      for (int i = 0; i < 16; i++) begin
         #1;
         chk("clear_busy", int'(busy), 1);
         chk("clear_ready", int'(prog_ready), 0);
         tick();
      end
`endif
   endtask

   initial begin
      for (int i = 0; i < 16; i++) m_mem[i] = -1;
      m_phase = P_RUN; m_words = 0; m_mar = 0; m_mdr = 0; m_clear_left = 0;
      rst_n = 1'b0; bus_in = 8'h00; prog_mode = 1'b0; prog_valid = 1'b0; prog_data = 8'h00;
      idle_ctl();
      tick();
      rst_n = 1'b1;
      #1;
`ifdef MEM_CLEAR_EN
      chk("reset_busy", int'(busy), 1);
`else
      chk("reset_busy", int'(busy), 0);
`endif
      chk("reset_ready", int'(prog_ready), 0);
      chk("reset_done", int'(prog_done), 0);
      chk("reset_oe", int'(bus_oe), 0);
      chk("reset_out", int'(bus_out), 0);
      wait_clear();

      // Full program load at one word per clock.
      prog_mode = 1'b1;
      tick();
      for (int i = 0; i < 16; i++) begin
         #1;
         chk("load_ready", int'(prog_ready), 1);
         chk("load_busy", int'(busy), 1);
         prog_word(8'(8'h10 + i));
      end
      #1;
      chk("load_done", int'(prog_done), 1);
      chk("load_done_ready", int'(prog_ready), 0);
      chk("load_done_busy", int'(busy), 1);
      prog_mode = 1'b0;
      tick();
      chk("run_done_clr", int'(prog_done), 0);
      chk("run_busy", int'(busy), 0);

      // CPU path table: {L_MA, L_MD, CE, L_R, bus_in, exp_oe, exp_out}.
      tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'hF5, 1'b0, 8'h00};
      tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 8'h15};
      tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h03, 1'b1, 8'h15};
      tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b1, 8'h13};
      tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h13};
      tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 8'hA5};
      tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
      tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 8'hA5};
      tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 8'h00};
      tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h07, 1'b1, 8'hA5};
      tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 8'h17};
      tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h03, 1'b1, 8'h17};
      tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 8'h5A};
      tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00};
      for (int i = 0; i < 14; i++) begin
         mar_addr_load_n = tbl[i].l_ma;
         mar_mem_load_n  = tbl[i].l_md;
         ram_en_n        = tbl[i].ce;
         ram_load_n      = tbl[i].l_r;
         bus_in          = tbl[i].bin;
         #1;
         chk($sformatf("vec%0d_oe", i), int'(bus_oe), int'(tbl[i].exp_oe));
         chk($sformatf("vec%0d_out", i), int'(bus_out), int'(tbl[i].exp_out));
         $display("vec %0d bus_in %02h oe %0b out %02h", i, bus_in, bus_oe, bus_out);
         tick();
      end
      idle_ctl();

      // Partial load with a 3-cycle stall, then abort.
      prog_mode = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) prog_word(8'(8'h80 + i));
      prog_data = 8'hEE;
      for (int i = 0; i < 3; i++) tick();
      prog_mode = 1'b0;
      tick();
      #1;
      chk("abort_busy", int'(busy), 0);
      chk("abort_ready", int'(prog_ready), 0);
      chk("abort_done", int'(prog_done), 0);
      read_addr(4, 8'h84);
      read_addr(5, 8'h15);
      prog_mode = 1'b1;
      tick();
      prog_word(8'h99);
      prog_mode = 1'b0;
      tick();
      read_addr(0, 8'h99);
      read_addr(1, 8'h81);

      // Reset after the 7th word, with an 8th word offered during reset.
      prog_mode = 1'b1;
      tick();
      for (int i = 0; i < 7; i++) prog_word(8'(8'h40 + i));
      rst_n = 1'b0; prog_mode = 1'b0; prog_valid = 1'b1; prog_data = 8'hFF;
      tick();
      rst_n = 1'b1; prog_valid = 1'b0;
`ifndef MEM_CLEAR_EN
      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_ready", int'(prog_ready), 0);
      ram_en_n = 1'b0;
      #1;
      chk("rst_mar0", int'(bus_out), 8'h40);
      tick();
      ram_en_n = 1'b1;
      read_addr(6, 8'h46);
      read_addr(7, 8'h17);
      prog_mode = 1'b1;
      tick();
      prog_word(8'h77);
      prog_mode = 1'b0;
      tick();
      read_addr(0, 8'h77);
`else
      prog_mode = 1'b1;
      wait_clear();
      #1;
      chk("clear_run", int'(busy), 0);
      tick();
      #1;
      chk("clear_then_prog", int'(prog_ready), 1);
      prog_mode = 1'b0;
      tick();
      for (int a = 0; a < 16; a++) read_addr(a, 0);
`endif

      // Randomized traffic against the model.
      for (int n = 0; n < 600; n++) begin
         rst_n           = ($urandom_range(0, 99) != 0);
         if ($urandom_range(0, 19) == 0) prog_mode = ~prog_mode;
         prog_valid      = 1'($urandom);
         prog_data       = 8'($urandom);
         bus_in          = 8'($urandom);
         mar_addr_load_n = 1'($urandom);
         mar_mem_load_n  = 1'($urandom);
         ram_en_n        = 1'($urandom);
         ram_load_n      = ($urandom_range(0, 3) != 0);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
